// File: rtl/seq_restoring_divider_if.sv
// Handshake/result bundle for seq_restoring_divider.
// Optional feature macro: SIGNED_DIV_EN adds the signed_op request bit.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef SIGNED_DIV_EN
    logic             signed_op;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

`ifdef SIGNED_DIV_EN
    modport master (output start, dividend, divisor, signed_op,
                    input  busy, done, quotient, remainder, div_by_zero);
    modport slave  (input  start, dividend, divisor, signed_op,
                    output busy, done, quotient, remainder, div_by_zero);
`else
    modport master (output start, dividend, divisor,
                    input  busy, done, quotient, remainder, div_by_zero);
    modport slave  (input  start, dividend, divisor,
                    output busy, done, quotient, remainder, div_by_zero);
`endif
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional feature macro: SIGNED_DIV_EN (two's-complement divide selected by signed_op).
module seq_restoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, qsh_q, dvs_q;
    logic             neg_quo_q, neg_rem_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             dbz_q;

    logic             accept, last_iter;
    logic [WIDTH:0]   trial_p, trial_t;
    logic [WIDTH-1:0] rem_d, qsh_d, quo_fix, rem_fix;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             neg_quo_d, neg_rem_d;

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

`ifdef SIGNED_DIV_EN
    // Divide magnitudes; signs are reapplied when the last quotient bit lands.
    logic dvd_neg, dvs_neg;
    assign dvd_neg   = bus.signed_op & bus.dividend[WIDTH-1];
    assign dvs_neg   = bus.signed_op & bus.divisor[WIDTH-1];
    assign dvd_mag   = negate_if(bus.dividend, dvd_neg);
    assign dvs_mag   = negate_if(bus.divisor, dvs_neg);
    assign neg_quo_d = dvd_neg ^ dvs_neg;
    assign neg_rem_d = dvd_neg;
`else
    assign dvd_mag   = bus.dividend;
    assign dvs_mag   = bus.divisor;
    assign neg_quo_d = 1'b0;
    assign neg_rem_d = 1'b0;
`endif

    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and start acceptance; start is only honoured outside RUN.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) state_d = S_IDLE;
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = (bus.divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, keep the trial only if it did not borrow.
    always_comb begin
        trial_p = {rem_q, qsh_q[WIDTH-1]};
        trial_t = trial_p - {1'b0, dvs_q};
        rem_d   = trial_p[WIDTH-1:0];
        qsh_d   = {qsh_q[WIDTH-2:0], 1'b0};
        if (!trial_t[WIDTH]) begin
            rem_d = trial_t[WIDTH-1:0];
            qsh_d = {qsh_q[WIDTH-2:0], 1'b1};
        end
        quo_fix = negate_if(qsh_d, neg_quo_q);
        rem_fix = negate_if(rem_d, neg_rem_q);
    end

    // Working registers: loaded on accept, advanced once per RUN cycle; reset not needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_q     <= '0;
            qsh_q     <= dvd_mag;
            dvs_q     <= dvs_mag;
            cnt_q     <= '0;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end else if (state_q == S_RUN) begin
            rem_q <= rem_d;
            qsh_q <= qsh_d;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Visible results: updated only when a divide completes, flag cleared on any accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (accept && (bus.divisor == '0)) begin
            quotient_q  <= '1;
            remainder_q <= bus.dividend;
            dbz_q       <= 1'b1;
        end else if (accept) begin
            dbz_q       <= 1'b0;
        end else if ((state_q == S_RUN) && last_iter) begin
            quotient_q  <= quo_fix;
            remainder_q <= rem_fix;
        end
    end

    assign bus.busy        = (state_q == S_RUN);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider with a plain-arithmetic reference model.
// Optional feature macro: SIGNED_DIV_EN enables the signed directed and random cases.
module tb_seq_restoring_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_restoring_divider_if #(.WIDTH(W)) bus();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer division straight from the arithmetic definition.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        z  = 1'b0;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (sg) begin
            if ((a == {1'b1, {(W-1){1'b0}}}) && (b == '1)) begin
                q = a;
                r = '0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen (start already low).
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                          input int inject);
        logic [W-1:0] eq, er;
        logic         ez;
        int           n;
        ref_div(a, b, sg, eq, er, ez);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
`ifdef SIGNED_DIV_EN
        bus.signed_op = sg;
`endif
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (bus.done !== 1'b1 && n <= W + 5) begin
            chk("busy_in_run", bus.busy, 1);
            if (n == inject) begin
                bus.start    = 1'b1;
                bus.dividend = 50;
                bus.divisor  = 5;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        chk("latency", n, (b == '0) ? 1 : W + 1);
        chk("busy_with_done", bus.busy, 0);
        chk("quotient", bus.quotient, eq);
        chk("remainder", bus.remainder, er);
        chk("div_by_zero", bus.div_by_zero, ez);
    endtask

    // One cycle after done: pulse over, back to idle, results held.
    task automatic check_after_done(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
        logic [W-1:0] eq, er;
        logic         ez;
        ref_div(a, b, sg, eq, er, ez);
        @(negedge clk);
        chk("done_pulse_width", bus.done, 0);
        chk("idle_not_busy", bus.busy, 0);
        chk("quotient_hold", bus.quotient, eq);
        chk("remainder_hold", bus.remainder, er);
        chk("dbz_hold", bus.div_by_zero, ez);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        logic         saw_done;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
`ifdef SIGNED_DIV_EN
        bus.signed_op = 1'b0;
`endif
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed unsigned cases.
        do_div(100, 7, 1'b0, -1);
        check_after_done(100, 7, 1'b0);
        do_div(32'hFFFF_FFFF, 1, 1'b0, -1);
        do_div(5, 9, 1'b0, -1);
        do_div(1234, 0, 1'b0, -1);
        do_div(8, 2, 1'b0, -1);            // accepted during the DONE cycle
        check_after_done(8, 2, 1'b0);
        do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
        do_div(0, 3, 1'b0, -1);

        // Start while busy is ignored, and new operands must not leak in.
        do_div(100, 7, 1'b0, 10);
        check_after_done(100, 7, 1'b0);

        // Reset mid-operation.
        bus.start    = 1'b1;
        bus.dividend = 100;
        bus.divisor  = 7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_quotient", bus.quotient, 0);
        chk("abort_remainder", bus.remainder, 0);
        chk("abort_dbz", bus.div_by_zero, 0);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw_done = saw_done | bus.done;
        end
        chk("no_done_after_abort", saw_done, 0);
        do_div(9, 3, 1'b0, -1);

`ifdef SIGNED_DIV_EN
        do_div(-32'sd7, 2, 1'b1, -1);
        do_div(7, -32'sd2, 1'b1, -1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
        do_div(-32'sd1234, 0, 1'b1, -1);
        do_div(-32'sd7, 2, 1'b0, -1);
        check_after_done(-32'sd7, 2, 1'b0);
`endif

        // Randomised operands across several divisor magnitudes.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom_range(0, 15);
                1:       rb = $urandom;
                2:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = ra >> $urandom_range(0, 8);
            endcase
            rs = 1'b0;
`ifdef SIGNED_DIV_EN
            rs = $urandom_range(0, 1);
`endif
            do_div(ra, rb, rs, -1);
            if ((i % 4) == 0) check_after_done(ra, rb, rs);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
